// File: rtl/btn_load_conditioner_if.sv
// rtl/btn_load_conditioner_if.sv - button conditioner signal bundle
// Ports (slave view, used by btn_load_conditioner):
//   btn_in      in   N_BTN  raw asynchronous button levels, 1 = pressed
//   btn_level   out  N_BTN  debounced level per channel
//   load_pulse  out  N_BTN  one-cycle strobe per accepted press
//   busy        out  1      some channel has a level change pending
interface btn_load_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] load_pulse;
    logic             busy;

    modport master (
        output btn_in,
        input  btn_level,
        input  load_pulse,
        input  busy
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output load_pulse,
        output busy
    );
endinterface

// File: rtl/btn_load_conditioner.sv
// rtl/btn_load_conditioner.sv - synchronize, debounce and strobe the ALU load buttons
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   bus    slave modport of btn_load_conditioner_if
//          (btn_in -> btn_level, load_pulse, busy)
// Channel bit order is {opcode, y, x}; channels are fully independent.
module btn_load_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    btn_load_conditioner_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] pulse_v;
    logic [N_BTN-1:0] pending_nxt;
    logic             busy_q;

    // Two-flop synchronizer; only sync2 is allowed to reach the FSMs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             level, level_nxt;
        logic             pulse, pulse_nxt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                level <= level_nxt;
                pulse <= pulse_nxt;
            end
        end

        // The counter clears on every state change, so it never exceeds
        // CNT_LAST and cannot wrap.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            level_nxt = level;
            pulse_nxt = 1'b0;
            case (state)
                IDLE: begin
                    level_nxt = 1'b0;
                    cnt_nxt   = '0;
                    if (sync2[i]) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2[i]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    level_nxt = 1'b1;
                    cnt_nxt   = '0;
                    if (!sync2[i]) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2[i]) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end
            endcase
        end

        assign level_v[i]     = level;
        assign pulse_v[i]     = pulse;
        assign pending_nxt[i] = (state_nxt == PRESS_WAIT) || (state_nxt == RELEASE_WAIT);
    end

    // busy is registered from the next-state decode so it tracks the
    // waiting states exactly, edge for edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |pending_nxt;
        end
    end

    assign bus.btn_level  = level_v;
    assign bus.load_pulse = pulse_v;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_btn_load_conditioner.sv
// tb/tb_btn_load_conditioner.sv - randomized self-checking bench for btn_load_conditioner
module tb_btn_load_conditioner;
    localparam int N = 3;
    localparam int D = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    btn_load_conditioner_if #(.N_BTN(N)) bus();

    btn_load_conditioner #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: each channel holds an accepted level and the length of the
    // current run of synchronized samples disagreeing with it. A run of D
    // such samples flips the level; a press flip also yields a strobe.
    logic [N-1:0] hist[$];
    bit           ml[N];
    int           mr[N];
    logic [N-1:0] mpulse;
    int           pcnt[N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        for (int i = 0; i < N; i++) begin
            ml[i] = 1'b0;
            mr[i] = 0;
        end
        mpulse = '0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] b);
        logic [N-1:0] s;
        s = hist.pop_front();
        hist.push_back(b);
        mpulse = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] != ml[i]) begin
                mr[i]++;
                if (mr[i] == D) begin
                    ml[i]     = s[i];
                    mr[i]     = 0;
                    mpulse[i] = s[i];
                end
            end else begin
                mr[i] = 0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [N-1:0] lv;
        logic         bz;
        bz = 1'b0;
        for (int i = 0; i < N; i++) begin
            lv[i] = ml[i];
            if (mr[i] > 0) bz = 1'b1;
        end
        check_eq({tag, ".level"}, 32'(bus.btn_level), 32'(lv));
        check_eq({tag, ".pulse"}, 32'(bus.load_pulse), 32'(mpulse));
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'(bz));
    endtask

    task automatic step(input logic [N-1:0] b, input string tag);
        bus.btn_in = b;
        @(posedge clk);
        if (reset) model_edge(b);
        else model_reset();
        #1;
        check_outputs(tag);
        for (int i = 0; i < N; i++) pcnt[i] += int'(bus.load_pulse[i]);
    endtask

    task automatic steps(input logic [N-1:0] b, input int n, input string tag);
        for (int k = 0; k < n; k++) step(b, tag);
    endtask

    task automatic clear_pcnt();
        for (int i = 0; i < N; i++) pcnt[i] = 0;
    endtask

    // Called 1 time unit after an edge; asserts reset mid-cycle.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
    endtask

    task automatic release_reset();
        #2;
        reset = 1'b1;
    endtask

    int           run_left[N];
    logic [N-1:0] rnd_val;

    initial begin
        reset = 1'b0;
        bus.btn_in = '0;
        model_reset();
        clear_pcnt();
        #2;
        check_outputs("reset_init");

        // Buttons held through reset: silent until reset lifts, then one
        // strobe on every channel.
        steps(3'b111, 5, "reset_hold");
        release_reset();
        clear_pcnt();
        steps(3'b111, 10, "reset_release");
        check_eq("reset_release.pulses0", 32'(pcnt[0]), 32'd1);
        check_eq("reset_release.pulses2", 32'(pcnt[2]), 32'd1);
        steps(3'b000, 10, "idle");

        clear_pcnt();
        steps(3'b001, 20, "clean_press");
        check_eq("clean_press.pulses", 32'(pcnt[0]), 32'd1);

        clear_pcnt();
        step(3'b011, "bounce");
        step(3'b001, "bounce");
        step(3'b011, "bounce");
        step(3'b011, "bounce");
        step(3'b001, "bounce");
        steps(3'b001, 10, "bounce_settle");
        check_eq("bounce.pulses", 32'(pcnt[1]), 32'd0);

        clear_pcnt();
        steps(3'b000, 2, "short_release");
        steps(3'b001, 10, "short_release_back");
        check_eq("short_release.level", 32'(bus.btn_level[0]), 32'd1);
        steps(3'b000, 10, "long_release");
        check_eq("long_release.level", 32'(bus.btn_level[0]), 32'd0);
        steps(3'b001, 10, "repress");
        check_eq("repress.pulses", 32'(pcnt[0]), 32'd1);

        steps(3'b000, 10, "idle2");
        clear_pcnt();
        steps(3'b110, 10, "simultaneous");
        check_eq("simultaneous.pulses1", 32'(pcnt[1]), 32'd1);
        check_eq("simultaneous.pulses2", 32'(pcnt[2]), 32'd1);

        steps(3'b000, 10, "idle3");
        steps(3'b001, 4, "midcount_press");
        async_reset("midcount_reset");
        steps(3'b001, 2, "midcount_hold");
        release_reset();
        clear_pcnt();
        steps(3'b001, 4, "midcount_early");
        check_eq("midcount.early_pulses", 32'(pcnt[0]), 32'd0);
        steps(3'b001, 6, "midcount_late");
        check_eq("midcount.pulses", 32'(pcnt[0]), 32'd1);

        // Random per-channel runs, long and short relative to D, with
        // occasional asynchronous resets.
        rnd_val = '0;
        for (int i = 0; i < N; i++) run_left[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (run_left[i] == 0) begin
                    rnd_val[i] = ~rnd_val[i];
                    run_left[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, D) : $urandom_range(D + 1, 14);
                end
                run_left[i]--;
            end
            step(rnd_val, "random");
            if ($urandom_range(0, 399) == 0) begin
                async_reset("random_reset");
                steps(rnd_val, $urandom_range(1, 3), "random_in_reset");
                release_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/btn_load_conditioner.md
# btn_load_conditioner

Conditions the three raw Basys3 load push-buttons (opcode, y, x) into clean, synchronized, single-cycle load strobes for the switch-fed ALU data registers. It sits directly upstream of the ALU data/load stage. Each channel has a two-flop synchronizer, a debounce counter and a four-state FSM. Each accepted press produces exactly one strobe; releases and bounce produce none.

## Interface
- N_BTN, 3, number of independent button channels; bit order {opcode, y, x}
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset
- btn_in  input  N_BTN  raw, asynchronous, bouncing button levels (1 = pressed)
- btn_level  output  N_BTN  debounced button level per channel
- load_pulse  output  N_BTN  one-cycle strobe on each accepted press; drives the ALU stage's load input
- busy  output  1  OR over channels of "FSM not in IDLE or HELD" (a change is pending)

## Operation
- The channels are fully independent. There is no priority or mutual exclusion. Simultaneous presses give simultaneous strobes.
- Synchronizer per bit: sync1 <= btn_in, sync2 <= sync1. Only sync2 feeds the FSM. Reset value is 0.
- FSM per channel, all outputs registered:
  - IDLE: level 0, counter 0. If sync2 = 1, go to PRESS_WAIT with counter = 1.
  - PRESS_WAIT: if sync2 = 0, go to IDLE and clear the counter. Else if counter = DEBOUNCE_CYCLES−1, go to HELD, clear the counter, set level 1 and pulse 1. Else increment the counter.
  - HELD: level 1. If sync2 = 0, go to RELEASE_WAIT with counter = 1.
  - RELEASE_WAIT: if sync2 = 1, go to HELD and clear the counter. Else if counter = DEBOUNCE_CYCLES−1, go to IDLE, clear the counter and set level 0. No pulse is issued. Else increment the counter.
- load_pulse[i] is 1 only in the cycle immediately after the PRESS_WAIT→HELD transition edge. It is cleared on every other edge.
- The counter never wraps. It is bounded by DEBOUNCE_CYCLES−1 because it clears on every transition.
- A held button produces exactly one pulse, however long it is held. A new pulse needs a full accepted release followed by a full accepted press.
- A glitch shorter than DEBOUNCE_CYCLES sync2 cycles in either direction is fully absorbed. The counter restarts from zero on the next change.
- Reset asserted at any time: within the same cycle, asynchronously, all FSMs go to IDLE, all counters and synchronizers go to 0, and btn_level, load_pulse and busy go to 0.
- After reset deasserts, a button already held is treated as a new press. It yields one pulse once the debounce window completes.

## Timing
- Reset values: btn_level = 0, load_pulse = 0, busy = 0.
- Press latency: take edge E0 as the first edge that samples btn_in = 1, and assume btn_in stays 1. Then sync2 = 1 after edge E1, and the FSM enters PRESS_WAIT at E2. btn_level and load_pulse rise at edge E(DEBOUNCE_CYCLES+1).
- load_pulse width: exactly 1 clk cycle. btn_level rises on the same edge as the pulse.
- Release latency: btn_level falls DEBOUNCE_CYCLES+1 edges after the first edge that samples btn_in = 0.
- busy is high from the edge entering PRESS_WAIT or RELEASE_WAIT until the edge leaving it.
- Throughput: at most one pulse per channel per 2·DEBOUNCE_CYCLES cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and CNT_W = 3.
- Reset: hold reset = 0 with btn_in = 3'b111 -> btn_level = 0, load_pulse = 0 and busy = 0 throughout. Release reset -> load_pulse = 3'b111 for exactly one cycle, 5 edges after the first sampling edge.
- Clean press: btn_in[0] rises and is held for 20 cycles -> load_pulse = 3'b001 for one cycle at E5, and btn_level[0] = 1 from E5 on. No further pulses.
- Bounce: btn_in[1] toggles 1,0,1,1,0 on successive cycles, then stays 0 -> no pulse, btn_level[1] stays 0, busy pulses high, then the channel returns to IDLE.
- Release and re-press: the held channel 0 is released for 2 cycles (absorbed; still HELD and no pulse), then for 10 cycles (btn_level[0] falls at E5 with no pulse), then re-pressed -> exactly one new pulse.
- Simultaneous: btn_in = 3'b110 on the same edge -> load_pulse = 3'b110 in a single cycle.
- Reset mid-count: reset is asserted during PRESS_WAIT (counter = 2) -> outputs go to 0 immediately. After release with the button still held, the pulse arrives a full 5 edges later, not earlier.
